clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider: the parametrised successor of the fixed divide-by-2 toggle divider. It divides `clk` by any integer D in [2, 2^WIDTH−1] and produces two outputs:

- a registered square wave `clk_out`, 50% duty for even D, high for one extra cycle for odd D;
- a one-cycle `tick` strobe at the start of each output period.

The divisor is changed at runtime through a load/busy handshake. A new divisor takes effect only at a period boundary, so `clk_out` never produces a runt pulse. The block sits in the clock-generation area and feeds clock-enable and strobe consumers in the `clk` domain.

---
 rtl/clk_div_prog.sv | 91 +++++++++
 tb/tb_clk_div_prog.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider (D in [2, 2^WIDTH-1]) with a period-start tick.
// New divisors are staged through a load/busy handshake and applied only at a period wrap.
module clk_div_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);

  logic [WIDTH-1:0] cur_div;
  logic [WIDTH-1:0] pend_div;
  logic             pend_valid;

  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0] pend_div_nxt;
  logic             pend_valid_nxt;
  logic             clk_out_nxt;
  logic             tick_nxt;
  logic             wrap;
  logic             accept;
  logic             reject;
  logic [WIDTH:0]   half;

  assign div_busy = pend_valid;

  always_comb begin
    cnt_nxt        = cnt;
    div_nxt        = cur_div;
    pend_div_nxt   = pend_div;
    pend_valid_nxt = pend_valid;
    wrap           = (cnt == cur_div - WIDTH'(1));
    accept         = div_load && !pend_valid && (div_val >= WIDTH'(2));
    reject         = div_load && !accept;

    if (en) begin
      if (wrap) begin
        cnt_nxt = '0;
        if (pend_valid) begin
          div_nxt        = pend_div;
          pend_valid_nxt = 1'b0;
        end
      end else begin
        cnt_nxt = cnt + WIDTH'(1);
      end
    end

    // Acceptance needs pend_valid low, so it can never collide with an apply.
    if (accept) begin
      pend_valid_nxt = 1'b1;
      pend_div_nxt   = div_val;
    end

    // One extra bit keeps (D+1)>>1 exact at D = 2^WIDTH-1.
    half        = ({1'b0, div_nxt} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    clk_out_nxt = en ? ({1'b0, cnt_nxt} < half) : clk_out;
    tick_nxt    = en && (cnt_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_div    <= RST_DIV;
      cnt        <= RST_DIV - WIDTH'(1);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      div_err    <= 1'b0;
    end else begin
      cur_div    <= div_nxt;
      cnt        <= cnt_nxt;
      pend_div   <= pend_div_nxt;
      pend_valid <= pend_valid_nxt;
      clk_out    <= clk_out_nxt;
      tick       <= tick_nxt;
      div_err    <= reject;
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: stimulus pushes hand-derived expectations into a
// queue, a monitor pops one entry per clock and compares all outputs.
module tb_clk_div_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_busy;
  logic       div_err;
  logic       clk_out;
  logic       tick;
  logic [7:0] cnt;

  typedef struct {
    logic       co;
    logic       tk;
    logic [7:0] cn;
    logic       bz;
    logic       er;
    int         phase;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;

  clk_div_prog #(.WIDTH(8), .RESET_DIV(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_busy (div_busy),
    .div_err  (div_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .cnt      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every output update is checked 1 time unit after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (clk_out !== e.co || tick !== e.tk || cnt !== e.cn ||
            div_busy !== e.bz || div_err !== e.er) begin
          errors++;
          $display("FAIL phase%0d check%0d: got clk_out=%b tick=%b cnt=%0d busy=%b err=%b, expected clk_out=%b tick=%b cnt=%0d busy=%b err=%b",
                   e.phase, checks, clk_out, tick, cnt, div_busy, div_err,
                   e.co, e.tk, e.cn, e.bz, e.er);
        end
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic cyc(input logic r, input logic e, input logic ld, input logic [7:0] v,
                     input logic eco, input logic etk, input logic [7:0] ecn,
                     input logic ebz, input logic eer);
    exp_t x;
    rst = r; en = e; div_load = ld; div_val = v;
    x.co = eco; x.tk = etk; x.cn = ecn; x.bz = ebz; x.er = eer; x.phase = phase;
    q.push_back(x);
    @(negedge clk);
  endtask

  // Free-running phases from..to of a period with divisor d and high time h.
  task automatic run(input int d, input int h, input int from, input int to, input logic bz);
    for (int i = from; i <= to; i++) begin
      logic [7:0] c;
      c = i[7:0];
      if (i >= d) begin
        errors++;
        $display("FAIL bench phase index %0d outside divisor %0d", i, d);
      end
      cyc(1'b0, 1'b1, 1'b0, 8'd0, (i < h), (i == 0), c, bz, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = 8'd0;
    @(negedge clk);

    // Reset state and legacy divide-by-2 toggle.
    phase = 1;
    cyc(1, 1, 0, 0, 0, 0, 8'd1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 8'd1, 0, 0);
    run(2, 1, 0, 1, 0);
    run(2, 1, 0, 1, 0);

    // Load 5 on a wrap edge: applied at the following wrap, not this one.
    phase = 2;
    cyc(0, 1, 1, 8'd5, 1, 1, 8'd0, 1, 0);
    cyc(0, 1, 0, 0,    0, 0, 8'd1, 1, 0);
    run(5, 3, 0, 4, 0);
    run(5, 3, 0, 4, 0);

    // Load 3 -> pattern 1,1,0.
    phase = 3;
    cyc(0, 1, 1, 8'd3, 1, 1, 8'd0, 1, 0);
    run(5, 3, 1, 4, 1);
    run(3, 2, 0, 2, 0);
    run(3, 2, 0, 2, 0);

    // D=8, then mid-period load of 6 while cnt=2.
    phase = 4;
    cyc(0, 1, 1, 8'd8, 1, 1, 8'd0, 1, 0);
    run(3, 2, 1, 2, 1);
    run(8, 4, 0, 2, 0);
    cyc(0, 1, 1, 8'd6, 1, 0, 8'd3, 1, 0);
    run(8, 4, 4, 7, 1);
    run(6, 3, 0, 5, 0);
    run(6, 3, 0, 5, 0);

    // Rejected loads of 0 and 1: one-cycle error, divisor unchanged.
    phase = 5;
    cyc(0, 1, 1, 8'd0, 1, 1, 8'd0, 0, 1);
    cyc(0, 1, 0, 0,    1, 0, 8'd1, 0, 0);
    cyc(0, 1, 1, 8'd1, 1, 0, 8'd2, 0, 1);
    cyc(0, 1, 0, 0,    0, 0, 8'd3, 0, 0);
    run(6, 3, 4, 5, 0);
    run(6, 3, 0, 5, 0);

    // Second load while busy is rejected; the first pending value (4) wins.
    phase = 6;
    cyc(0, 1, 1, 8'd4, 1, 1, 8'd0, 1, 0);
    cyc(0, 1, 1, 8'd7, 1, 0, 8'd1, 1, 1);
    cyc(0, 1, 0, 0,    1, 0, 8'd2, 1, 0);
    run(6, 3, 3, 5, 1);
    run(4, 2, 0, 3, 0);

    // Enable gating at cnt=1 for 3 cycles stretches the period to 7.
    phase = 7;
    run(4, 2, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 8'd1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 8'd1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 8'd1, 0, 0);
    run(4, 2, 2, 3, 0);
    run(4, 2, 0, 3, 0);

    // Load accepted while disabled, then maximum divisor 255: 128 high, 127 low.
    phase = 8;
    cyc(0, 0, 1, 8'd255, 0, 0, 8'd3, 1, 0);
    run(255, 128, 0, 254, 0);

    // Reset while a load is pending discards it.
    phase = 9;
    cyc(0, 1, 1, 8'd9, 1, 1, 8'd0, 1, 0);
    run(255, 128, 1, 5, 1);
    cyc(1, 1, 0, 0,    0, 0, 8'd1, 0, 0);
    cyc(1, 1, 1, 8'd9, 0, 0, 8'd1, 0, 0);
    run(2, 1, 0, 1, 0);
    run(2, 1, 0, 1, 0);
    run(2, 1, 0, 1, 0);
    run(2, 1, 0, 1, 0);
    run(2, 1, 0, 1, 0);
    run(2, 1, 0, 1, 0);

    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
